mp_mem: RTL and testbench

- Parametrised N-port synchronous memory; successor to the two-port memory.
- Generalised in port count, data width and depth; adds byte-write strobes, round-robin arbitration of same-address conflicts, an explicit read-data valid, and out-of-range error reporting.
- Per-port valid/ready request handshake, matching the existing port interface style, so port agents and monitors extend directly.

---
 rtl/mp_mem_pkg.sv | 68 ++++++
 rtl/mp_mem_if.sv | 29 ++
 rtl/mp_mem_arb.sv | 68 ++++++
 rtl/mp_mem.sv | 89 ++++++++
 tb/tb_mp_mem.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mp_mem_pkg.sv
// mp_mem_pkg: shared definitions for the N-port memory.
//   OP_READ / OP_WRITE : request opcode encoding
//   strb_merge         : byte-masked write of one word
//   first_from         : first set bit of a mask at or after a pointer, cyclically
//   next_rr            : round-robin pointer update from the conflict winners
// The helper functions work on fixed maximum widths (MAX_PORTS ports,
// MAX_DATA_W data bits). Callers zero-extend their operands and truncate
// the result, so these limits bound NPORTS and DATA_W.
package mp_mem_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int MAX_PORTS  = 32;
    localparam int MAX_DATA_W = 512;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    typedef logic [MAX_PORTS-1:0]  port_mask_t;
    typedef logic [MAX_DATA_W-1:0] word_t;
    typedef logic [MAX_STRB_W-1:0] strb_t;

    // Byte i of the result is data byte i where strb[i]=1, otherwise old byte i.
    function automatic word_t strb_merge(input word_t old_word, input word_t data,
                                         input strb_t strb);
        word_t res;
        res = old_word;
        for (int b = 0; b < MAX_STRB_W; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = data[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Index of the first set bit of mask scanning ptr, ptr+1, ... modulo n.
    // Returns ptr when the mask is empty (callers only use it on non-empty masks).
    function automatic logic [31:0] first_from(input port_mask_t mask, input logic [31:0] ptr,
                                               input logic [31:0] n);
        logic [31:0] idx;
        logic [31:0] res;
        logic        found;
        res   = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            idx = ptr + 32'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((32'(k) < n) && !found && mask[idx[4:0]]) begin
                found = 1'b1;
                res   = idx;
            end
        end
        return res;
    endfunction

    // Pointer moves just past the lowest-indexed winner; no winners, no move.
    function automatic logic [31:0] next_rr(input logic [31:0] ptr, input port_mask_t winners,
                                            input logic [31:0] n);
        logic [31:0] lowest;
        if (winners == '0) begin
            return ptr;
        end
        lowest = first_from(winners, 32'd0, n);
        return (lowest + 32'd1 >= n) ? 32'd0 : lowest + 32'd1;
    endfunction

endpackage

// File: rtl/mp_mem_if.sv
// mp_mem_if: per-port request/response bundle of the N-port memory.
//   valid/op/addr/wr_data/wr_strb : request, driven by the master (requester)
//   ready                         : request accepted when valid && ready
//   rd_data/rd_valid/err          : registered response, driven by the slave (memory)
interface mp_mem_if #(
    parameter int NPORTS = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [NPORTS-1:0]                   valid;
    logic [NPORTS-1:0]                   op;
    logic [NPORTS-1:0][ADDR_W-1:0]       addr;
    logic [NPORTS-1:0][DATA_W-1:0]       wr_data;
    logic [NPORTS-1:0][DATA_W/8-1:0]     wr_strb;
    logic [NPORTS-1:0]                   ready;
    logic [NPORTS-1:0][DATA_W-1:0]       rd_data;
    logic [NPORTS-1:0]                   rd_valid;
    logic [NPORTS-1:0]                   err;

    modport master (
        output valid, op, addr, wr_data, wr_strb,
        input  ready, rd_data, rd_valid, err
    );

    modport slave (
        input  valid, op, addr, wr_data, wr_strb,
        output ready, rd_data, rd_valid, err
    );
endinterface

// File: rtl/mp_mem_arb.sv
// mp_mem_arb: same-address conflict arbiter with round-robin priority.
//   clk, rst  : clock, synchronous active-high reset (clears rr_ptr, forces ready=0)
//   valid_i   : request valid per port
//   op_i      : 0 = read, 1 = write
//   addr_i    : word address per port
//   ready_o   : combinational grant per port
// Ports with the same in-range address form a group; a group containing a
// write and at least two members grants only its first member at or after
// rr_ptr. rr_ptr_q is held here; rr_ptr_d is its next value.
module mp_mem_arb
    import mp_mem_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NPORTS-1:0]              valid_i,
    input  logic [NPORTS-1:0]              op_i,
    input  logic [NPORTS-1:0][ADDR_W-1:0]  addr_i,
    output logic [NPORTS-1:0]              ready_o
);
    localparam int PTR_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [PTR_W-1:0]  rr_ptr_q;
    logic [PTR_W-1:0]  rr_ptr_d;
    logic [NPORTS-1:0] contender;   // valid and in range: eligible to conflict
    logic [NPORTS-1:0] conflict;
    logic [NPORTS-1:0] winner;

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_contender
            assign contender[gi] = valid_i[gi] && (32'(addr_i[gi]) < 32'(DEPTH));
        end

        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            logic [NPORTS-1:0] group;   // ports sharing this port's address
            logic [31:0]       pick;

            always_comb begin
                group = '0;
                for (int q = 0; q < NPORTS; q++) begin
                    group[q] = contender[q] && (addr_i[q] == addr_i[gi]);
                end
            end

            // Every member of a group computes the same pick, so at most one wins.
            assign pick         = first_from(MAX_PORTS'(group), 32'(rr_ptr_q), 32'(NPORTS));
            assign conflict[gi] = contender[gi] && ($countones(group) > 1)
                                  && ((group & op_i) != '0);
            assign winner[gi]   = conflict[gi] && (pick == 32'(gi));
            assign ready_o[gi]  = !rst && (!conflict[gi] || winner[gi]);
        end
    endgenerate

    assign rr_ptr_d = PTR_W'(next_rr(32'(rr_ptr_q), MAX_PORTS'(winner), 32'(NPORTS)));

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/mp_mem.sv
// mp_mem: NPORTS-port synchronous memory, DEPTH words of DATA_W bits.
//   clk, rst : clock, synchronous active-high reset (clears memory and responses)
//   bus      : mp_mem_if slave; per port valid/op/addr/wr_data/wr_strb requests,
//              combinational ready, registered rd_data/rd_valid/err one cycle later.
// Writes are byte-masked by wr_strb. Out-of-range addresses are accepted,
// leave memory untouched and pulse err (reads also return zero data).
// Same-cycle writes never collide on an address: the arbiter serialises them.
module mp_mem
    import mp_mem_pkg::*;
#(
    parameter  int NPORTS = 4,
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input logic      clk,
    input logic      rst,
    mp_mem_if.slave  bus
);
    logic [NPORTS-1:0]             ready;
    logic [NPORTS-1:0]             in_range;
    logic [NPORTS-1:0]             rd_acc;
    logic [NPORTS-1:0]             wr_acc;

    logic [DATA_W-1:0]             mem_q [DEPTH];
    logic [NPORTS-1:0][DATA_W-1:0] rd_data_q;
    logic [NPORTS-1:0][DATA_W-1:0] rd_data_d;
    logic [NPORTS-1:0]             rd_valid_q;
    logic [NPORTS-1:0]             rd_valid_d;
    logic [NPORTS-1:0]             err_q;
    logic [NPORTS-1:0]             err_d;

    mp_mem_arb #(
        .NPORTS (NPORTS),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .valid_i (bus.valid),
        .op_i    (bus.op),
        .addr_i  (bus.addr),
        .ready_o (ready)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_port
            logic acc;
            assign in_range[gi] = 32'(bus.addr[gi]) < 32'(DEPTH);
            assign acc          = bus.valid[gi] && ready[gi];
            assign rd_acc[gi]   = acc && (bus.op[gi] == OP_READ);
            assign wr_acc[gi]   = acc && (bus.op[gi] == OP_WRITE) && in_range[gi];
            assign err_d[gi]    = acc && !in_range[gi];
            assign rd_valid_d[gi] = rd_acc[gi];
            // rd_data keeps its last value between reads.
            assign rd_data_d[gi] = rd_acc[gi] ? (in_range[gi] ? mem_q[bus.addr[gi]] : '0)
                                              : rd_data_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                mem_q[d] <= '0;
            end
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            err_q      <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                if (wr_acc[p]) begin
                    mem_q[bus.addr[p]] <= DATA_W'(strb_merge(MAX_DATA_W'(mem_q[bus.addr[p]]),
                                                             MAX_DATA_W'(bus.wr_data[p]),
                                                             MAX_STRB_W'(bus.wr_strb[p])));
                end
            end
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    assign bus.ready    = ready;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_mp_mem.sv
// tb_mp_mem: directed bench for mp_mem (4 ports, 32-bit, DEPTH=12).
// A behavioural model (memory array, round-robin pointer, per-address
// grouping) is compared against the DUT on every falling edge; directed
// sections add hand-computed literal expectations.
module tb_mp_mem;
    import mp_mem_pkg::*;

    localparam int NP    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 12;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mp_mem_if #(.NPORTS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();

    mp_mem #(.NPORTS(NP), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    int            m_rr   = 0;
    bit            m_live = 0;
    logic [NP-1:0] e_rv;
    logic [NP-1:0] e_err;
    logic [DW-1:0] e_rd [NP];

    always @(negedge clk) begin : model_chk
        logic [NP-1:0] e_ready;
        logic [NP-1:0] acc;
        int            cnt;
        int            w;
        int            low_win;
        int            a_p;
        bit            has_wr;
        bit            any_win;

        e_ready = rst ? '0 : '1;
        any_win = 0;
        low_win = NP;
        if (!rst) begin
            for (int a = 0; a < DEPTH; a++) begin
                cnt    = 0;
                has_wr = 0;
                for (int p = 0; p < NP; p++) begin
                    if (bus.valid[p] && int'(bus.addr[p]) == a) begin
                        cnt++;
                        if (bus.op[p]) has_wr = 1;
                    end
                end
                if (cnt >= 2 && has_wr) begin
                    w = -1;
                    for (int k = 0; k < NP; k++) begin
                        int q;
                        q = (m_rr + k) % NP;
                        if (w < 0 && bus.valid[q] && int'(bus.addr[q]) == a) w = q;
                    end
                    for (int p = 0; p < NP; p++) begin
                        if (p != w && bus.valid[p] && int'(bus.addr[p]) == a) e_ready[p] = 1'b0;
                    end
                    any_win = 1;
                    if (w < low_win) low_win = w;
                end
            end
        end

        check("ready", 64'(bus.ready), 64'(e_ready));
        if (m_live) begin
            check("rd_valid", 64'(bus.rd_valid), 64'(e_rv));
            check("err", 64'(bus.err), 64'(e_err));
            for (int p = 0; p < NP; p++) begin
                check($sformatf("rd_data[%0d]", p), 64'(bus.rd_data[p]), 64'(e_rd[p]));
            end
        end

        if (rst) begin
            for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
            for (int p = 0; p < NP; p++) e_rd[p] = '0;
            e_rv   = '0;
            e_err  = '0;
            m_rr   = 0;
            m_live = 1;
        end else begin
            acc = bus.valid & e_ready;
            for (int p = 0; p < NP; p++) begin
                a_p      = int'(bus.addr[p]);
                e_rv[p]  = acc[p] && !bus.op[p];
                e_err[p] = acc[p] && a_p >= DEPTH;
                if (e_rv[p]) e_rd[p] = (a_p < DEPTH) ? m_mem[a_p] : '0;
                if (acc[p])
                    $display("txn t=%0t port %0d %s addr %0d wdata %h strb %h", $time, p,
                             bus.op[p] ? "WR" : "RD", a_p, bus.wr_data[p], bus.wr_strb[p]);
            end
            for (int p = 0; p < NP; p++) begin
                a_p = int'(bus.addr[p]);
                if (acc[p] && bus.op[p] && a_p < DEPTH) begin
                    for (int b = 0; b < DW / 8; b++) begin
                        if (bus.wr_strb[p][b]) m_mem[a_p][b*8 +: 8] = bus.wr_data[p][b*8 +: 8];
                    end
                end
            end
            if (any_win) m_rr = (low_win + 1) % NP;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic req(input int p, input bit w, input int a, input logic [31:0] d,
                       input logic [3:0] s);
        bus.valid[p]   = 1'b1;
        bus.op[p]      = w;
        bus.addr[p]    = AW'(a);
        bus.wr_data[p] = d;
        bus.wr_strb[p] = s;
    endtask

    task automatic drop(input int p);
        bus.valid[p] = 1'b0;
    endtask

    task automatic idle();
        bus.valid = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
        $fatal(1);
    end

    logic [31:0] rot_exp [NP];
    logic [NP-1:0] acc_s;

    initial begin
        rot_exp[0] = 32'h11; rot_exp[1] = 32'h12; rot_exp[2] = 32'h13; rot_exp[3] = 32'h10;
        bus.valid = '0; bus.op = '0; bus.addr = '0; bus.wr_data = '0; bus.wr_strb = '0;
        rst = 1'b1;
        tick(); tick();
        mid(); check("init_rst_ready", 64'(bus.ready), 64'h0);
        tick(); rst = 1'b0;

        // Reset clears memory; ready low throughout reset.
        req(0, 1, 3, 32'hDEADBEEF, 4'hF);
        mid(); check("rst_wr_ready", 64'(bus.ready[0]), 64'h1);
        tick(); idle();
        rst = 1'b1;
        req(1, 0, 3, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            mid(); check("rst_hold_ready", 64'(bus.ready), 64'h0);
            tick();
        end
        rst = 1'b0;
        mid(); check("post_rst_rd_ready", 64'(bus.ready[1]), 64'h1);
        tick(); idle();
        mid();
        check("post_rst_rd_valid", 64'(bus.rd_valid[1]), 64'h1);
        check("post_rst_rd_data", 64'(bus.rd_data[1]), 64'h0);

        // Disjoint parallel writes then rotated reads.
        tick();
        for (int p = 0; p < NP; p++) req(p, 1, p, 32'h10 + 32'(p), 4'hF);
        mid(); check("disj_wr_ready", 64'(bus.ready), 64'hF);
        tick();
        for (int p = 0; p < NP; p++) req(p, 0, (p + 1) % NP, 32'h0, 4'h0);
        mid(); check("disj_rd_ready", 64'(bus.ready), 64'hF);
        tick(); idle();
        mid();
        check("disj_rd_valid", 64'(bus.rd_valid), 64'hF);
        for (int p = 0; p < NP; p++) check($sformatf("disj_rd_data[%0d]", p),
                                           64'(bus.rd_data[p]), 64'(rot_exp[p]));

        // Write-write conflict at rr_ptr=0.
        tick();
        req(0, 1, 5, 32'h11, 4'hF); req(2, 1, 5, 32'h22, 4'hF);
        mid();
        check("ww_ready0", 64'(bus.ready[0]), 64'h1);
        check("ww_ready2", 64'(bus.ready[2]), 64'h0);
        tick(); drop(0);
        mid(); check("ww_retry_ready2", 64'(bus.ready[2]), 64'h1);
        tick(); idle(); req(0, 0, 5, 32'h0, 4'h0);
        mid(); tick(); idle();
        mid(); check("ww_readback", 64'(bus.rd_data[0]), 64'h22);

        // Read-read on one address, then read-write with rr_ptr steered to 2.
        tick();
        for (int p = 0; p < NP; p++) req(p, 0, 7, 32'h0, 4'h0);
        mid(); check("rr_all_ready", 64'(bus.ready), 64'hF);
        tick(); idle();
        req(1, 1, 7, 32'h77, 4'hF); req(2, 0, 7, 32'h0, 4'h0);   // rr_ptr=1: port1 wins
        mid(); check("rw1_ready", 64'(bus.ready[2:1]), 64'h1);
        tick(); drop(1);
        mid(); check("rw1_retry_ready2", 64'(bus.ready[2]), 64'h1);
        tick(); idle();
        req(1, 1, 7, 32'h99, 4'hF); req(3, 0, 7, 32'h0, 4'h0);   // rr_ptr=2: port3 wins
        mid();
        check("rw1_rd_data2", 64'(bus.rd_data[2]), 64'h77);
        check("rw2_ready3", 64'(bus.ready[3]), 64'h1);
        check("rw2_ready1", 64'(bus.ready[1]), 64'h0);
        tick(); drop(3);
        mid();
        check("rw2_retry_ready1", 64'(bus.ready[1]), 64'h1);
        check("rw2_old_value", 64'(bus.rd_data[3]), 64'h77);
        tick(); idle(); req(0, 0, 7, 32'h0, 4'h0);
        mid(); tick(); idle();
        mid(); check("rw2_new_value", 64'(bus.rd_data[0]), 64'h99);

        // Byte strobes.
        tick(); req(0, 1, 8, 32'hAABBCCDD, 4'hF);
        tick(); req(0, 1, 8, 32'h11223344, 4'b0101);
        tick(); req(0, 0, 8, 32'h0, 4'h0);
        mid(); tick(); req(0, 1, 8, 32'hFFFFFFFF, 4'h0);
        mid(); check("strb_merge", 64'(bus.rd_data[0]), 64'hAA22CC44);
        tick(); req(0, 0, 8, 32'h0, 4'h0);
        mid(); tick(); idle();
        mid(); check("strb_zero", 64'(bus.rd_data[0]), 64'hAA22CC44);

        // Out of range: two writes to addr 13 never conflict.
        tick(); req(0, 1, 13, 32'h55, 4'hF); req(1, 1, 13, 32'h66, 4'hF);
        mid(); check("oor_wr_ready", 64'(bus.ready[1:0]), 64'h3);
        tick(); idle();
        mid();
        check("oor_wr_err", 64'(bus.err[1:0]), 64'h3);
        check("oor_wr_no_rdv", 64'(bus.rd_valid[1:0]), 64'h0);
        tick(); req(1, 0, 0, 32'h0, 4'h0);
        mid(); tick(); req(1, 0, 13, 32'h0, 4'h0);
        mid(); check("pre_oor_rd_data", 64'(bus.rd_data[1]), 64'h10);
        tick(); idle();
        mid();
        check("oor_rd_valid", 64'(bus.rd_valid[1]), 64'h1);
        check("oor_rd_data", 64'(bus.rd_data[1]), 64'h0);
        check("oor_rd_err", 64'(bus.err[1]), 64'h1);

        // Streaming reads on port2.
        tick();
        for (int i = 0; i < 4; i++) begin
            req(2, 0, i, 32'h0, 4'h0);
            mid(); tick();
        end
        idle();
        mid(); check("stream_last", 64'(bus.rd_data[2]), 64'h13);

        // Patterned multi-port traffic; each port holds its request until accepted.
        tick();
        acc_s = '0;
        for (int c = 0; c < 40; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (!bus.valid[p] || acc_s[p]) begin
                    if ((c + 2 * p) % 7 == 0) begin
                        drop(p);
                    end else begin
                        req(p, ((c + p) % 3) == 0,
                            (c % 2 == 0) ? (c / 2) % 14 : (c * 3 + p * 5) % 14,
                            {8'(c), 8'(p), 16'hA5C3 ^ 16'(c * 37 + p)}, 4'((c * 3 + p) % 16));
                    end
                end
            end
            mid(); acc_s = bus.valid & bus.ready;
            tick();
        end
        idle();

        // Sweep every word to expose any stray write.
        for (int a = 0; a < DEPTH; a++) begin
            req(0, 0, a, 32'h0, 4'h0);
            mid(); tick();
        end
        idle();
        mid(); tick(); mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
